axi_lite_to_mm: RTL and testbench

//  AXI4-Lite slave that turns PS-side register transactions into the simple

---
 rtl/axi_lite_to_mm_if.sv | 33 +++
 rtl/axi_lite_to_mm.sv | 165 ++++++++++++++++
 tb/tb_axi_lite_to_mm.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_to_mm_if.sv
// AXI4-Lite slave-side bundle between the PS GP master and axi_lite_to_mm.
interface axi_lite_to_mm_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_to_mm.sv
// AXI4-Lite slave to single-cycle MM strobe bridge for the PL register file.
// Optional macro AXI_LITE_ADDR_CHECK_EN: word index >= NUM_REGS answers SLVERR with no strobe.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order), readies follow the held flags
// W_EXEC | one-cycle wr_en pulse
// W_RESP | bvalid held until bready
// R_IDLE | arready high, waiting for AR
// R_EXEC | one-cycle rd_en pulse, rd_din registered into rdata
// R_DATA | rvalid held until rready
module axi_lite_to_mm #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 3
) (
    input  logic                    aclk,
    input  logic                    areset,
    axi_lite_to_mm_if.slave         s_axi,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_dout,
    output logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   rd_din
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_LITE_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic aw_held;
    logic w_held;
    logic w_err;
    logic r_err;
    logic aw_fire;
    logic w_fire;
    logic ar_fire;
    logic aw_err;
    logic ar_err;
    logic [ADDR_WIDTH-3:0] aw_word;

    assign aw_fire = s_axi.awvalid && s_axi.awready;
    assign w_fire  = s_axi.wvalid && s_axi.wready;
    assign ar_fire = s_axi.arvalid && s_axi.arready;

    // AW may land in the same cycle the write launches, so decode the live address then.
    assign aw_word = aw_fire ? s_axi.awaddr[ADDR_WIDTH-1:2] : wr_addr[ADDR_WIDTH-1:2];
    assign aw_err  = ADDR_CHECK && (32'(aw_word) >= 32'(NUM_REGS));
    assign ar_err  = ADDR_CHECK && (32'(s_axi.araddr[ADDR_WIDTH-1:2]) >= 32'(NUM_REGS));

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            w_err         <= 1'b0;
            wr_addr       <= '0;
            wr_dout       <= '0;
            wr_be         <= '0;
            wr_en         <= 1'b0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        wr_addr <= s_axi.awaddr;
                        aw_held <= 1'b1;
                    end
                    if (w_fire) begin
                        wr_dout <= s_axi.wdata;
                        wr_be   <= s_axi.wstrb;
                        w_held  <= 1'b1;
                    end
                    if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                        w_state       <= W_EXEC;
                        wr_en         <= !aw_err;
                        w_err         <= aw_err;
                        s_axi.awready <= 1'b0;
                        s_axi.wready  <= 1'b0;
                    end else begin
                        s_axi.awready <= !(aw_held || aw_fire);
                        s_axi.wready  <= !(w_held || w_fire);
                    end
                end
                W_EXEC: begin
                    wr_en        <= 1'b0;
                    s_axi.bvalid <= 1'b1;
                    s_axi.bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
                    w_state      <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.bresp   <= RESP_OKAY;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= R_IDLE;
            r_err         <= 1'b0;
            rd_addr       <= '0;
            rd_en         <= 1'b0;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        rd_addr       <= s_axi.araddr;
                        rd_en         <= !ar_err;
                        r_err         <= ar_err;
                        s_axi.arready <= 1'b0;
                        r_state       <= R_EXEC;
                    end else begin
                        s_axi.arready <= 1'b1;
                    end
                end
                R_EXEC: begin
                    // rd_din is sampled before any same-cycle write lands, giving pre-write data.
                    rd_en        <= 1'b0;
                    s_axi.rdata  <= r_err ? '0 : rd_din;
                    s_axi.rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
                    s_axi.rvalid <= 1'b1;
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        s_axi.rvalid  <= 1'b0;
                        s_axi.arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_to_mm.sv
// Directed self-checking bench for axi_lite_to_mm; expectations follow AXI_LITE_ADDR_CHECK_EN.
module tb_axi_lite_to_mm;
    localparam int AW = 8;
    localparam int DW = 32;

`ifdef AXI_LITE_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    axi_lite_to_mm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_dout, rd_din;
    logic [3:0]    wr_be;
    logic          wr_en, rd_en;
    logic [DW-1:0] regs [4];

    assign rd_din = regs[rd_addr[3:2]];

    axi_lite_to_mm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(3)) dut (
        .aclk(clk), .areset(areset), .s_axi(bus.slave),
        .wr_addr(wr_addr), .wr_dout(wr_dout), .wr_be(wr_be), .wr_en(wr_en),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_din(rd_din)
    );

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int rd_count = 0;

    always @(posedge clk) begin
        if (wr_en) wr_count <= wr_count + 1;
        if (rd_en) rd_count <= rd_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_en, rd_en} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_en, rd_en});
        end
        checks++;
        if ({wr_addr, wr_dout, wr_be, rd_addr, bus.rdata, bus.bresp, bus.rresp} !== '0) begin
            errors++;
            $display("FAIL reset_data: outputs not all zero (wr_addr=%h wr_dout=%h rdata=%h)",
                     wr_addr, wr_dout, bus.rdata);
        end
        tick();
        areset = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_readies: got %b expected 111",
                     {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_write();
        int c0;
        c0 = wr_count;
        tick();
        bus.awvalid = 1'b1; bus.awaddr = 8'h04;
        bus.wvalid = 1'b1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready} !== 2'b11) begin
            errors++;
            $display("FAIL write_readies: got %b expected 11", {bus.awready, bus.wready});
        end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_dout, wr_be, bus.bvalid} !== {1'b1, 8'h04, 32'h1234_5678, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL write_strobe: got en=%b addr=%h data=%h be=%h bvalid=%b expected 1 04 12345678 f 0",
                     wr_en, wr_addr, wr_dout, wr_be, bus.bvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wr_en, bus.bvalid, bus.bresp} !== 4'b0100) begin
            errors++;
            $display("FAIL write_bresp: got en=%b bvalid=%b bresp=%b expected 0 1 00",
                     wr_en, bus.bvalid, bus.bresp);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.awready} !== 2'b01 || wr_count - c0 != 1) begin
            errors++;
            $display("FAIL write_done: got bvalid=%b awready=%b pulses=%0d expected 0 1 1",
                     bus.bvalid, bus.awready, wr_count - c0);
        end
    endtask

    task automatic test_split();
        int c0;
        c0 = wr_count;
        tick();
        bus.wvalid = 1'b1; bus.wdata = 32'hA5A5_0001; bus.wstrb = 4'h3;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.wready, wr_en} !== 2'b00) begin
                errors++;
                $display("FAIL split_wait%0d: got wready=%b wr_en=%b expected 0 0", i, bus.wready, wr_en);
            end
            tick();
        end
        bus.awvalid = 1'b1; bus.awaddr = 8'h08;
        tick();
        bus.awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_dout, wr_be} !== {1'b1, 8'h08, 32'hA5A5_0001, 4'h3}) begin
            errors++;
            $display("FAIL split_strobe: got en=%b addr=%h data=%h be=%h expected 1 08 a5a50001 3",
                     wr_en, wr_addr, wr_dout, wr_be);
        end
        tick();
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_count - c0 != 1) begin
            errors++;
            $display("FAIL split_pulses: got %0d expected 1", wr_count - c0);
        end
    endtask

    task automatic test_read();
        regs[2] = 32'hCAFE_F00D;
        tick();
        bus.arvalid = 1'b1; bus.araddr = 8'h08;
        tick();
        bus.arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_en, rd_addr, bus.rvalid} !== {1'b1, 8'h08, 1'b0}) begin
            errors++;
            $display("FAIL read_strobe: got en=%b addr=%h rvalid=%b expected 1 08 0", rd_en, rd_addr, bus.rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rd_en, bus.rvalid, bus.rresp, bus.rdata} !== {1'b0, 1'b1, 2'b00, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL read_data: got en=%b rvalid=%b rresp=%b rdata=%h expected 0 1 00 cafef00d",
                     rd_en, bus.rvalid, bus.rresp, bus.rdata);
        end
        regs[2] = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({bus.rvalid, bus.arready, bus.rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
                errors++;
                $display("FAIL read_hold%0d: got rvalid=%b arready=%b rdata=%h expected 1 0 cafef00d",
                         i, bus.rvalid, bus.arready, bus.rdata);
            end
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            errors++;
            $display("FAIL read_done: got rvalid=%b arready=%b expected 0 1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_backpressure();
        tick();
        bus.awvalid = 1'b1; bus.awaddr = 8'h00;
        bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_0000; bus.wstrb = 4'hF;
        tick();
        bus.wvalid = 1'b0; bus.awaddr = 8'h04;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.bvalid, bus.awready, wr_en} !== 3'b100) begin
                errors++;
                $display("FAIL bp_hold%0d: got bvalid=%b awready=%b wr_en=%b expected 1 0 0",
                         i, bus.bvalid, bus.awready, wr_en);
            end
            tick();
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'hBEEF_0004;
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
            errors++;
            $display("FAIL bp_release: got bvalid=%b awready=%b wready=%b expected 0 1 1",
                     bus.bvalid, bus.awready, bus.wready);
        end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_dout} !== {1'b1, 8'h04, 32'hBEEF_0004}) begin
            errors++;
            $display("FAIL bp_second: got en=%b addr=%h data=%h expected 1 04 beef0004", wr_en, wr_addr, wr_dout);
        end
        tick();
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic test_reset_mid();
        regs[1] = 32'h5555_AAAA;
        tick();
        bus.arvalid = 1'b1; bus.araddr = 8'h04;
        tick();
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 8'h08;
        bus.wvalid = 1'b1; bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, bus.rvalid} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_setup: got wr_en=%b rvalid=%b expected 1 1", wr_en, bus.rvalid);
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.rvalid, wr_en, rd_en, bus.awready, bus.wready, bus.arready} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got %b expected 0000000",
                     {bus.bvalid, bus.rvalid, wr_en, rd_en, bus.awready, bus.wready, bus.arready});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b00111) begin
            errors++;
            $display("FAIL rstmid_idle: got %b expected 00111",
                     {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready});
        end
        bus.awvalid = 1'b1; bus.awaddr = 8'h04;
        bus.wvalid = 1'b1; bus.wdata = 32'h600D_0004; bus.wstrb = 4'hF;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_dout} !== {1'b1, 8'h04, 32'h600D_0004}) begin
            errors++;
            $display("FAIL rstmid_fresh: got en=%b addr=%h data=%h expected 1 04 600d0004", wr_en, wr_addr, wr_dout);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.bresp} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_bresp: got bvalid=%b bresp=%b expected 1 00", bus.bvalid, bus.bresp);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic test_zero_strobe();
        tick();
        bus.awvalid = 1'b1; bus.awaddr = 8'h00;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'h0;
        @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, wr_en} !== 3'b010) begin
            errors++;
            $display("FAIL zs_aw_first: got awready=%b wready=%b wr_en=%b expected 0 1 0",
                     bus.awready, bus.wready, wr_en);
        end
        tick();
        bus.wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_be} !== {1'b1, 8'h00, 4'h0}) begin
            errors++;
            $display("FAIL zs_strobe: got en=%b addr=%h be=%h expected 1 00 0", wr_en, wr_addr, wr_be);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.bresp} !== 3'b100) begin
            errors++;
            $display("FAIL zs_bresp: got bvalid=%b bresp=%b expected 1 00", bus.bvalid, bus.bresp);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic test_addr_check();
        logic          exp_en;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_rdata;
        exp_en    = !CHK;
        exp_resp  = CHK ? 2'b10 : 2'b00;
        exp_rdata = CHK ? 32'h0 : 32'h0BAD_BEEF;
        regs[3] = 32'h0BAD_BEEF;
        tick();
        bus.arvalid = 1'b1; bus.araddr = 8'h0C;
        tick();
        bus.arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_en !== exp_en) begin
            errors++;
            $display("FAIL ac_rd_en: got %b expected %b", rd_en, exp_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.rvalid, bus.rresp, bus.rdata} !== {1'b1, exp_resp, exp_rdata}) begin
            errors++;
            $display("FAIL ac_rresp: got rvalid=%b rresp=%b rdata=%h expected 1 %b %h",
                     bus.rvalid, bus.rresp, bus.rdata, exp_resp, exp_rdata);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        bus.awvalid = 1'b1; bus.awaddr = 8'h0C;
        bus.wvalid = 1'b1; bus.wdata = 32'h1212_1212; bus.wstrb = 4'hF;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== exp_en) begin
            errors++;
            $display("FAIL ac_wr_en: got %b expected %b", wr_en, exp_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.bresp} !== {1'b1, exp_resp}) begin
            errors++;
            $display("FAIL ac_bresp: got bvalid=%b bresp=%b expected 1 %b", bus.bvalid, bus.bresp, exp_resp);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        regs[0] = 32'h0000_0000;
        regs[1] = 32'h0000_0001;
        regs[2] = 32'h0000_0002;
        regs[3] = 32'h0000_0003;

        test_reset();
        test_write();
        test_split();
        test_read();
        test_backpressure();
        test_reset_mid();
        test_zero_strobe();
        test_addr_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
